// File: rtl/seven_seg_scanner.sv
// Time-multiplexed 4-digit hex scanner for an active-low seven-segment display.
// Optional macro SEVEN_SEG_LEADING_ZERO_BLANK_EN blanks leading zero digits 3..1.
module seven_seg_scanner #(
  parameter int unsigned REFRESH_DIV = 100000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] value,
  input  logic        load,
  input  logic        enable,
  output logic [6:0]  seg,
  output logic [3:0]  an,
  output logic        frame_done
);

  localparam int unsigned CNT_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);

  logic [CNT_W-1:0] refresh_cnt;
  logic [1:0]       digit_idx;
  logic [15:0]      pending;
  logic [15:0]      shown;

  logic       digit_tick_c;
  logic       frame_wrap_c;
  logic [3:0] nibble_c;
  logic [6:0] seg_dec_c;
  logic       blank_c;

  // Scan timing and nibble selection for the digit currently being driven
  always_comb begin
    digit_tick_c = (refresh_cnt == CNT_MAX);
    frame_wrap_c = digit_tick_c && (digit_idx == 2'd3);
    nibble_c     = 4'(shown >> {digit_idx, 2'b00});
  end

`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
  // A digit is blank when it and every more-significant nibble are zero
  always_comb begin
    blank_c = 1'b0;
    case (digit_idx)
      2'd3:    blank_c = (shown[15:12] == 4'h0);
      2'd2:    blank_c = (shown[15:8]  == 8'h00);
      2'd1:    blank_c = (shown[15:4]  == 12'h000);
      default: blank_c = 1'b0;
    endcase
  end
`else
  assign blank_c = 1'b0;
`endif

  // Hex to active-low gfedcba
  always_comb begin
    seg_dec_c = 7'b1111111;
    case (nibble_c)
      4'h0: seg_dec_c = 7'b1000000;
      4'h1: seg_dec_c = 7'b1111001;
      4'h2: seg_dec_c = 7'b0100100;
      4'h3: seg_dec_c = 7'b0110000;
      4'h4: seg_dec_c = 7'b0011001;
      4'h5: seg_dec_c = 7'b0010010;
      4'h6: seg_dec_c = 7'b0000010;
      4'h7: seg_dec_c = 7'b1111000;
      4'h8: seg_dec_c = 7'b0000000;
      4'h9: seg_dec_c = 7'b0010000;
      4'hA: seg_dec_c = 7'b0001000;
      4'hB: seg_dec_c = 7'b0000011;
      4'hC: seg_dec_c = 7'b1000110;
      4'hD: seg_dec_c = 7'b0100001;
      4'hE: seg_dec_c = 7'b0000110;
      4'hF: seg_dec_c = 7'b0001110;
      default: seg_dec_c = 7'b1111111;
    endcase
  end

  // Counters, double-buffered value, and registered display outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      refresh_cnt <= '0;
      digit_idx   <= 2'd0;
      pending     <= 16'h0000;
      shown       <= 16'h0000;
      an          <= 4'b1111;
      seg         <= 7'b1111111;
      frame_done  <= 1'b0;
    end else begin
      refresh_cnt <= digit_tick_c ? '0 : refresh_cnt + CNT_W'(1);
      if (digit_tick_c) begin
        digit_idx <= digit_idx + 2'd1;
      end
      frame_done <= frame_wrap_c;
      if (load) begin
        pending <= value;
      end
      // Shown only changes between frames so a digit set never tears
      if (frame_wrap_c) begin
        shown <= load ? value : pending;
      end
      if (enable && !blank_c) begin
        an  <= ~(4'b0001 << digit_idx);
        seg <= seg_dec_c;
      end else begin
        an  <= 4'b1111;
        seg <= 7'b1111111;
      end
    end
  end

endmodule

// File: doc/seven_seg_scanner.md
SEVEN_SEG_SCANNER -- requirements
Module: seven_seg_scanner

Interface
REQ-001 Parameter REFRESH_DIV, default 100000, clk cycles each digit stays lit; legal range 2..2^24.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous active-low reset: assertion takes effect immediately, release is sampled on clk.
REQ-004 value  input  16  hex value to display; digit i = value[4i+3:4i].
REQ-005 load  input  1  one-cycle strobe; captures value into the pending register.
REQ-006 enable  input  1  1 = drive display; 0 = blank all digits.
REQ-007 seg  output  7  cathodes {g,f,e,d,c,b,a}, active-low, registered.
REQ-008 an  output  4  anodes, active-low, one-hot-low, registered; an[i]=0 lights digit i.
REQ-009 frame_done  output  1  one-cycle pulse when a full 4-digit scan completes.

Function
REQ-010 refresh_cnt SHALL count 0..REFRESH_DIV-1 and wrap to 0; it runs regardless of enable.
REQ-011 On the cycle refresh_cnt = REFRESH_DIV-1, digit_idx (2 bits) SHALL increment, wrapping 3 -> 0.
REQ-012 frame_done SHALL pulse high for exactly the cycle following the digit_idx 3 -> 0 wrap; it is low at all other times.
REQ-013 load=1 SHALL write value into pending on that edge; a later load overwrites pending.
REQ-014 The shown register SHALL update only at the 3 -> 0 wrap: shown <= (load ? value : pending); a load on the wrap cycle goes to shown directly (no tearing within a frame).
REQ-015 seg/an SHALL reflect digit_idx with one cycle latency: an = ~(1<<digit_idx), seg = decode(shown nibble for digit_idx).
REQ-016 Decode (active-low, gfedcba): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
REQ-017 enable=0 SHALL force an=1111 and seg=1111111 on the next edge; counters, pending and shown keep updating.
REQ-018 enable 0 -> 1 SHALL resume output at the current digit_idx on the next edge, no scan restart.
REQ-019 Exactly zero or one an bit SHALL be low in every cycle.

Reset
REQ-020 While reset=0: refresh_cnt=0, digit_idx=0, pending=0, shown=0, an=1111, seg=1111111, frame_done=0.
REQ-021 First edge after release with enable=1: an=1110, seg=1000000 (digit 0 of 0x0000).
REQ-022 Reset asserted mid-scan SHALL discard pending and shown; no frame_done is emitted for the interrupted frame.

Configuration
REQ-023 Macro SEVEN_SEG_LEADING_ZERO_BLANK_EN defined: digit i (i=3,2,1) SHALL be blanked (an bit held 1, seg=1111111) when shown nibbles i..3 are all zero; digit 0 is always shown; scan timing and frame_done unchanged.
REQ-024 Macro undefined: all four digits SHALL be shown including leading zeros; no blanking logic is present.

Verification (REFRESH_DIV=4)
REQ-025 Reset release, enable=1, no load -> an cycles 1110,1101,1011,0111 every 4 clks, seg=1000000 throughout; frame_done pulses once every 16 clks.
REQ-026 load value=0x12AF mid-frame -> current frame unchanged; next frame shows digit0 F=0001110, digit1 A=0001000, digit2 2=0100100, digit3 1=1111001.
REQ-027 load 0x1111 then 0x2222 in the same frame -> next frame shows only 0x2222; load 0x3333 on the wrap cycle -> that frame shows 0x3333.
REQ-028 enable=0 for 10 clks mid-scan -> an=1111, seg=1111111 one edge later; on re-enable digit_idx matches an uninterrupted scan.
REQ-029 With SEVEN_SEG_LEADING_ZERO_BLANK_EN, value=0x0040 -> digits 3,2 blanked (an bits 1), digit1 shows 4=0011001, digit0 shows 0=1000000; value=0x0000 -> only digit 0 lit.
REQ-030 Reset asserted asynchronously mid-frame after load 0xBEEF -> outputs go to reset values immediately, without waiting for a clock edge; after release display shows 0x0000.
